mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the memory bus between DMA, D-cache and I-cache; one 4-word block per grant, no preemption.
// Commands are registered off the next state; each word waits for mem_valid; ready pulses the cycle after the last ack.
module mem_bus_arbiter #(
    parameter int WORD_SIZE   = 16,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             i_req,
    input  logic [15:0]                      i_addr,
    input  logic                             d_req,
    input  logic                             d_we,
    input  logic [15:0]                      d_addr,
    input  logic [WORD_SIZE*BLOCK_WORDS-1:0] d_wdata,
    input  logic                             BR,
    output logic                             BG,
    output logic                             mem_read,
    output logic                             mem_write,
    output logic [15:0]                      mem_addr,
    output logic [WORD_SIZE-1:0]             mem_wdata,
    input  logic [WORD_SIZE-1:0]             mem_rdata,
    input  logic                             mem_valid,
    output logic [WORD_SIZE*BLOCK_WORDS-1:0] fill_data,
    output logic                             i_ready,
    output logic                             d_ready,
    output logic                             bus_busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        I_FILL    = 3'd1,
        D_FILL    = 3'd2,
        D_WB      = 3'd3,
        DMA_GRANT = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t      state, state_nxt;
    logic [13:0] base;
    logic [1:0]  cnt;
    logic        in_fill, in_xfer, last_ack;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

    assign in_fill  = (state == I_FILL) || (state == D_FILL);
    assign in_xfer  = in_fill || (state == D_WB);
    assign last_ack = in_xfer && mem_valid && (cnt == 2'd3);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (BR)
                    state_nxt = DMA_GRANT;
                else if (d_req)
                    state_nxt = d_we ? D_WB : D_FILL;
                else if (i_req)
                    state_nxt = I_FILL;
            end
            I_FILL, D_FILL, D_WB: begin
                if (last_ack)
                    state_nxt = DONE;
            end
            DMA_GRANT: begin
                if (!BR)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up exactly with the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            BG        <= 1'b0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
        end else begin
            state     <= state_nxt;
            mem_read  <= (state_nxt == I_FILL) || (state_nxt == D_FILL);
            mem_write <= (state_nxt == D_WB);
            BG        <= (state_nxt == DMA_GRANT);
            i_ready   <= last_ack && (state == I_FILL);
            d_ready   <= last_ack && (state != I_FILL);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base <= '0;
            cnt  <= '0;
        end else if (state == IDLE && !BR && (d_req || i_req)) begin
            base <= d_req ? d_addr[15:2] : i_addr[15:2];
            cnt  <= '0;
        end else if (in_xfer && mem_valid) begin
            cnt <= cnt + 2'd1;
        end
    end

    // Words are overwritten in place, so the previous block stays visible until the next fill lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            fill_data <= '0;
        else if (in_fill && mem_valid)
            fill_data[cnt*WORD_SIZE +: WORD_SIZE] <= mem_rdata;
    end

    always_comb begin
        mem_wdata = '0;
        if (state == D_WB)
            mem_wdata = d_wdata[cnt*WORD_SIZE +: WORD_SIZE];
    end

    assign mem_addr = {base, cnt};
    assign bus_busy = (state != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: scoreboard queues hold expected addresses, write words and fill blocks.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, BR = 1'b0;
    logic [15:0] i_addr = '0, d_addr = '0;
    logic [63:0] d_wdata = '0;
    logic        BG, mem_read, mem_write, mem_valid = 1'b0;
    logic [15:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [63:0] fill_data;
    logic        i_ready, d_ready, bus_busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_addr_q[$];
    logic [15:0] exp_wdata_q[$];
    logic [63:0] exp_fill_q[$];

    mem_bus_arbiter #(.WORD_SIZE(16), .BLOCK_WORDS(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .BR(BR), .BG(BG),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .fill_data(fill_data), .i_ready(i_ready), .d_ready(d_ready), .bus_busy(bus_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a * 16'd3 + 16'h1000;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_block(input logic [15:0] addr, input logic wr, input logic [63:0] wdata);
        logic [15:0] b;
        logic [63:0] blk;
        b   = {addr[15:2], 2'b00};
        blk = '0;
        for (int k = 0; k < 4; k++) begin
            exp_addr_q.push_back(b + 16'(k));
            if (wr) exp_wdata_q.push_back(wdata[16*k +: 16]);
            blk[16*k +: 16] = mem_word(b + 16'(k));
        end
        if (!wr) exp_fill_q.push_back(blk);
    endtask

    // Memory model: sees a command, waits one cycle, then acks for one cycle.
    task automatic serve_word(input string tag);
        int n;
        logic [15:0] ea;
        n = 0;
        while (!(mem_read || mem_write) && n < 20) begin
            tick;
            n++;
        end
        check({tag, "_cmd"}, mem_read | mem_write, 1'b1);
        if (!(mem_read || mem_write)) return;
        check({tag, "_rd_wr_excl"}, mem_read & mem_write, 1'b0);
        ea = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 16'hxxxx;
        check({tag, "_addr"}, mem_addr, ea);
        if (mem_write)
            check({tag, "_wdata"}, mem_wdata, (exp_wdata_q.size() > 0) ? exp_wdata_q.pop_front() : 16'hxxxx);
        tick;
        mem_rdata = mem_word(mem_addr);
        mem_valid = 1'b1;
        tick;
        mem_valid = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic check_done(input string tag, input logic want_i, input logic want_d, input logic is_fill);
        check({tag, "_i_ready"}, i_ready, want_i);
        check({tag, "_d_ready"}, d_ready, want_d);
        if (is_fill)
            check({tag, "_fill_data"}, fill_data, (exp_fill_q.size() > 0) ? exp_fill_q.pop_front() : 64'hx);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1 reset_n = 1'b0;
        #2;
        check("rst_bg", BG, 0);
        check("rst_rd", mem_read, 0);
        check("rst_wr", mem_write, 0);
        check("rst_busy", bus_busy, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_fill", fill_data, 0);
        tick; tick;
        reset_n = 1'b1;
        tick;
        check("idle_busy", bus_busy, 0);

        // I-cache fill from 0x0105, words at 0x0104..0x0107
        i_req = 1'b1; i_addr = 16'h0105;
        expect_block(16'h0105, 1'b0, 64'h0);
        for (int k = 0; k < 4; k++) serve_word("ifill");
        check_done("ifill_done", 1'b1, 1'b0, 1'b1);
        check("ifill_busy_done", bus_busy, 1);
        i_req = 1'b0;
        tick;
        check("ifill_pulse_end", i_ready, 0);
        check("ifill_idle", bus_busy, 0);

        // Simultaneous i_req and d_req: D-fill first
        i_req = 1'b1; i_addr = 16'h0A0C;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
        expect_block(16'h0200, 1'b0, 64'h0);
        expect_block(16'h0A0C, 1'b0, 64'h0);
        for (int k = 0; k < 4; k++) serve_word("prio_d");
        check_done("prio_d_done", 1'b0, 1'b1, 1'b1);
        d_req = 1'b0;
        tick;
        check("prio_gap_idle", bus_busy, 0);
        check("prio_gap_rd", mem_read, 0);
        for (int k = 0; k < 4; k++) serve_word("prio_i");
        check_done("prio_i_done", 1'b1, 1'b0, 1'b1);
        i_req = 1'b0;
        tick;

        // D-cache write-back
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0310; d_wdata = 64'h4444_3333_2222_1111;
        expect_block(16'h0310, 1'b1, 64'h4444_3333_2222_1111);
        for (int k = 0; k < 4; k++) begin
            serve_word("wb");
            if (k < 3) check("wb_no_read", mem_read, 0);
        end
        check_done("wb_done", 1'b0, 1'b1, 1'b0);
        d_req = 1'b0; d_we = 1'b0;
        tick;
        check("wb_pulse_end", d_ready, 0);

        // BR during second word of an I-fill, with a D-fill pending
        i_req = 1'b1; i_addr = 16'h0520;
        expect_block(16'h0520, 1'b0, 64'h0);
        serve_word("br_i");
        BR = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0640;
        for (int k = 1; k < 4; k++) begin
            serve_word("br_i");
            check("br_no_preempt_bg", BG, 0);
        end
        check_done("br_i_done", 1'b1, 1'b0, 1'b1);
        i_req = 1'b0;
        tick;
        check("br_idle_bg", BG, 0);
        tick;
        check("br_grant_bg", BG, 1);
        check("br_grant_rd", mem_read, 0);
        check("br_grant_wr", mem_write, 0);
        tick;
        check("br_hold_bg", BG, 1);
        BR = 1'b0;
        tick;
        check("br_release_bg", BG, 0);
        check("br_release_rd", mem_read, 0);
        expect_block(16'h0640, 1'b0, 64'h0);
        for (int k = 0; k < 4; k++) serve_word("br_d");
        check_done("br_d_done", 1'b0, 1'b1, 1'b1);
        d_req = 1'b0;
        tick;

        // Reset during third word of a D-fill
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h07A8;
        expect_block(16'h07A8, 1'b0, 64'h0);
        serve_word("rst_d");
        serve_word("rst_d");
        check("rst_d_third_rd", mem_read, 1);
        reset_n = 1'b0;
        #1;
        check("arst_rd", mem_read, 0);
        check("arst_busy", bus_busy, 0);
        check("arst_addr", mem_addr, 0);
        check("arst_fill", fill_data, 0);
        check("arst_d_ready", d_ready, 0);
        exp_addr_q.delete();
        exp_fill_q.delete();
        tick;
        check("arst_hold_d_ready", d_ready, 0);
        reset_n = 1'b1;
        expect_block(16'h07A8, 1'b0, 64'h0);
        for (int k = 0; k < 4; k++) serve_word("rerun_d");
        check_done("rerun_d_done", 1'b0, 1'b1, 1'b1);
        d_req = 1'b0;
        tick;
        check("final_idle", bus_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
